// File: rtl/mips_mem_pkg.sv
// Shared memory geometry for main, the loader bench and the dump reader, plus the dump FSM state encoding.
package mips_mem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        FINISH
    } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a window of words from a base address out of memory, one read in flight at a time.
// Latency: RD_LATENCY+2 cycles per word with out_ready high; done pulses one cycle after the last handshake.
// Backpressure: the word is held stable while out_ready is low; MEM_DUMP_CHECKSUM_EN enables a running output sum.
module mem_dump_reader #(
    parameter int ADDR_W     = mips_mem_pkg::ADDR_W,
    parameter int DATA_W     = mips_mem_pkg::DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum
);
    import mips_mem_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [2:0]        lat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            addr      <= base_addr;
                            remaining <= count;
                            mem_addr  <= base_addr;
                            mem_rd_en <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= 3'(RD_LATENCY);
                    state   <= WAIT;
                end
                WAIT: begin
                    // lat_cnt==1 marks the cycle the memory presents the word
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        out_data  <= mem_rdata;
                        out_addr  <= addr;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            mem_addr  <= addr + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Cleared on any start taken in IDLE, including count==0, then frozen after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (state == HOLD && out_ready) begin
            sum_q <= sum_q + out_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: a behavioural memory feeds the DUT and expected words are queued at start.
module tb_mem_dump_reader;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done, mem_rd_en, out_valid;
    logic [AW-1:0] mem_addr, out_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data, checksum;

    always #5 clk = ~clk;

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .checksum  (checksum)
    );

    logic [DW-1:0] mem [128];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            hs_cyc[$];
    int            done_cnt = 0;
    int            rd_cnt = 0;
    logic          stall_q = 1'b0;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    logic [DW-1:0] exp_sum = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_cnt++;
                check("one_outstanding", out_valid, 0);
            end
            if (done) done_cnt++;
            if (stall_q) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, held_a);
                check("hold_data", out_data, held_d);
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word_addr", out_addr, mon_e.a);
                    check("word_data", out_data, mon_e.d);
                end
            end
            stall_q = out_valid && !out_ready;
            held_a  = out_addr;
            held_d  = out_data;
        end
    end

    function automatic logic [DW-1:0] exp_ck();
`ifdef MEM_DUMP_CHECKSUM_EN
        return exp_sum;
`else
        return '0;
`endif
    endfunction

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        exp_sum   = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + AW'(i);
            sb.push_back('{a, mem[a]});
            exp_sum += mem[a];
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        if (!done) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_busy_at_done"}, busy, 0);
            check({tag, "_checksum"}, checksum, exp_ck());
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < budget);
        if (!out_valid) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int k;
        for (int i = 0; i < 128; i++) mem[i] = DW'(i * 3);

        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // basic window with back-to-back words
        hs_cyc.delete();
        done_cnt = 0;
        do_start(7'd5, 8'd3);
        @(negedge clk);
        check("busy_after_start", busy, 1);
        wait_done(60, "t1");
        check("t1_words_left", sb.size(), 0);
        check("t1_words_seen", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("t1_gap0", hs_cyc[1] - hs_cyc[0], LAT + 2);
            check("t1_gap1", hs_cyc[2] - hs_cyc[1], LAT + 2);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        check("t1_checksum_54", checksum, 54);
`endif
        repeat (3) @(negedge clk);
        #1;
        check("t1_done_once", done_cnt, 1);

        // checksum wrap
        mem[5] = 32'hFFFF_FFFF;
        mem[6] = 32'h2;
        do_start(7'd5, 8'd2);
        wait_done(60, "ck");
`ifdef MEM_DUMP_CHECKSUM_EN
        check("ck_wrap_1", checksum, 1);
`endif
        mem[5] = 32'd15;
        mem[6] = 32'd18;

        // backpressure on the first word
        out_ready = 1'b0;
        rd_cnt = 0;
        do_start(7'd0, 8'd2);
        wait_valid(20, "bp");
        repeat (10) @(negedge clk);
        #1;
        check("bp_one_read", rd_cnt, 1);
        check("bp_addr", out_addr, 0);
        check("bp_data", out_data, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(60, "bp");
        check("bp_words_left", sb.size(), 0);
        check("bp_two_reads", rd_cnt, 2);

        // address wrap
        do_start(7'd126, 8'd4);
        wait_done(80, "wrap");
        check("wrap_words_left", sb.size(), 0);
        check("wrap_last_addr", out_addr, 1);

        // count==0
        @(negedge clk);
        #1;
        done_cnt = 0;
        do_start(7'd9, 8'd0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("zero_done_pulse", done, 0);
        check("zero_done_count", done_cnt, 1);

        // start while busy is ignored
        done_cnt = 0;
        do_start(7'd10, 8'd3);
        start     = 1'b1;
        base_addr = 7'd50;
        count     = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(60, "ign");
        check("ign_words_left", sb.size(), 0);
        check("ign_last_addr", out_addr, 12);
        repeat (5) @(negedge clk);
        #1;
        check("ign_done_once", done_cnt, 1);
        check("ign_idle_valid", out_valid, 0);

        // reset during HOLD of the second word
        hs_cyc.delete();
        do_start(7'd20, 8'd5);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (hs_cyc.size() < 1 && k < 30);
        check("rst_first_word", hs_cyc.size(), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_valid(20, "rst");
        check("rst_hold_addr", out_addr, 21);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_start(7'd40, 8'd2);
        wait_done(60, "after_rst");
        check("after_rst_words_left", sb.size(), 0);
        check("after_rst_last_addr", out_addr, 41);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
